// File: rtl/cache_mem_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_pkg
// Shared definitions for the cache memory-side responder:
//   - resp_state_t : responder FSM states
//   - word_idx_w() : width of the backing-store word index for a given depth
//   - LAT_CNT_W    : width of the access-latency down-counter
// -----------------------------------------------------------------------------
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        DRAIN     = 2'd2
    } resp_state_t;

    // Wide enough for any MEM_LATENCY up to 255 cycles.
    localparam int LAT_CNT_W = 8;

    function automatic int word_idx_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Posted write buffer holding {address, data} write-back entries.
// Ports:
//   clk, rst              clock, synchronous active-high reset (empties buffer)
//   push, push_addr/data  enqueue request (ignored while full)
//   pop                   dequeue head (ignored while empty)
//   full, empty           occupancy flags
//   head_addr/data        oldest entry
//   view_addr/data/valid  flat view ordered oldest (slot 0) to youngest,
//                         used by the forwarding compare
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_WIDTH-1:0]         push_addr,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [ADDR_WIDTH-1:0]         head_addr,
    output logic [DATA_WIDTH-1:0]         head_data,
    output logic [DEPTH*ADDR_WIDTH-1:0]   view_addr,
    output logic [DEPTH*DATA_WIDTH-1:0]   view_data,
    output logic [DEPTH-1:0]              view_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    logic [PW-1:0]         head_r;
    logic [PW-1:0]         tail_r;
    logic [PW:0]           count_r;
    logic                  push_s;
    logic                  pop_s;

    assign full   = (count_r == DEPTH_CNT);
    assign empty  = (count_r == {(PW+1){1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    assign head_addr = addr_r[head_r];
    assign head_data = data_r[head_r];

    // Pointer and occupancy tracking; simultaneous push+pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful where the view marks them valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_r[tail_r] <= push_addr;
            data_r[tail_r] <= push_data;
        end
    end

    // Age-ordered view: slot i is the i-th oldest entry.
    always_comb begin
        view_addr  = '0;
        view_data  = '0;
        view_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            view_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_r[head_r + PW'(i)];
            view_data[i*DATA_WIDTH +: DATA_WIDTH] = data_r[head_r + PW'(i)];
            view_valid[i] = ((PW+1)'(i) < count_r);
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
// Memory-side responder for the two-way write-back data cache. Dirty-line
// write-backs are posted into a small buffer and drained into a word-addressed
// backing store; refill reads are served from the store with fixed latency.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   : reads are accepted while write-backs are buffered; the youngest
//               matching entry is forwarded with 1-cycle latency.
//   undefined : no compare logic; reads wait until the buffer has drained.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_valid/wb_ready         write-back handshake (wb_ready = buffer not full)
//   wb_address, wb_data       write-back byte address and data
//   rd_valid/rd_ready         refill read handshake
//   rd_address                refill byte address
//   rd_resp_valid/_data       one-cycle registered response
//   busy                      FSM not idle or write buffer non-empty
// -----------------------------------------------------------------------------
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WB_DEPTH    = 4,
    parameter int MEM_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_address,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  busy
);

    localparam int IW = word_idx_w(MEM_WORDS);

    // Read miss: accept edge plus (MEM_LATENCY-1) wait edges gives a response
    // in cycle T+MEM_LATENCY. Drain: MEM_LATENCY edges after entering DRAIN.
    localparam logic [LAT_CNT_W-1:0] RD_CNT_LOAD = LAT_CNT_W'(MEM_LATENCY - 2);
    localparam logic [LAT_CNT_W-1:0] DR_CNT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

    resp_state_t           state_r;
    logic [LAT_CNT_W-1:0]  cnt_r;
    logic [IW-1:0]         rd_idx_r;
    logic                  rd_resp_valid_r;
    logic [DATA_WIDTH-1:0] rd_resp_data_r;
    logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

    logic                           fifo_full_s;
    logic                           fifo_empty_s;
    logic                           push_s;
    logic                           pop_s;
    logic                           rd_accept_s;
    logic                           fwd_hit_s;
    logic [DATA_WIDTH-1:0]          fwd_data_s;
    logic [ADDR_WIDTH-1:0]          head_addr_s;
    logic [DATA_WIDTH-1:0]          head_data_s;
    logic [WB_DEPTH*ADDR_WIDTH-1:0] view_addr_s;
    logic [WB_DEPTH*DATA_WIDTH-1:0] view_data_s;
    logic [WB_DEPTH-1:0]            view_valid_s;
    logic                           unused_bits_s;

    assign wb_ready      = !fifo_full_s;
    assign push_s        = wb_valid && wb_ready;
    assign rd_accept_s   = rd_valid && rd_ready;
    // Commit happens on the last drain cycle; a reset in that cycle discards it.
    assign pop_s         = (state_r == DRAIN) && (cnt_r == {LAT_CNT_W{1'b0}}) && !rst;
    assign busy          = (state_r != IDLE) || !fifo_empty_s;
    assign rd_resp_valid = rd_resp_valid_r;
    assign rd_resp_data  = rd_resp_data_r;

    wb_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_addr  (wb_address),
        .push_data  (wb_data),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head_addr  (head_addr_s),
        .head_data  (head_data_s),
        .view_addr  (view_addr_s),
        .view_data  (view_data_s),
        .view_valid (view_valid_s)
    );

`ifdef WB_FORWARD_EN
    assign rd_ready = (state_r == IDLE);

    // Forwarding compare on the full word address. The view runs oldest to
    // youngest, so a later match overrides an earlier one (youngest wins).
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (view_valid_s[i] &&
                (view_addr_s[i*ADDR_WIDTH+2 +: ADDR_WIDTH-2] == rd_address[ADDR_WIDTH-1:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = view_data_s[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign unused_bits_s = ^{rd_address[1:0], head_addr_s};
`else
    // Reads only start on an empty buffer, so memory is always up to date.
    assign rd_ready   = (state_r == IDLE) && fifo_empty_s;
    assign fwd_hit_s  = 1'b0;
    assign fwd_data_s = '0;

    assign unused_bits_s = ^{rd_address, head_addr_s, view_addr_s, view_data_s, view_valid_s};
`endif

    // Responder FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            cnt_r           <= {LAT_CNT_W{1'b0}};
            rd_idx_r        <= {IW{1'b0}};
            rd_resp_valid_r <= 1'b0;
            rd_resp_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A read wins over draining; every drain passes back
                    // through IDLE, so a waiting read is never starved.
                    if (rd_accept_s) begin
                        if (fwd_hit_s) begin
                            rd_resp_valid_r <= 1'b1;
                            rd_resp_data_r  <= fwd_data_s;
                        end else begin
                            state_r  <= READ_WAIT;
                            cnt_r    <= RD_CNT_LOAD;
                            rd_idx_r <= rd_address[2 +: IW];
                        end
                    end else if (!fifo_empty_s) begin
                        state_r <= DRAIN;
                        cnt_r   <= DR_CNT_LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ_WAIT: begin
                    if (cnt_r == {LAT_CNT_W{1'b0}}) begin
                        rd_resp_valid_r <= 1'b1;
                        rd_resp_data_r  <= mem_r[rd_idx_r];
                        state_r         <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DRAIN: begin
                    if (cnt_r == {LAT_CNT_W{1'b0}}) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Backing store: written by the final drain cycle, never reset.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            mem_r[head_addr_s[2 +: IW]] <= head_data_s;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_responder
// Directed scenarios followed by a randomized phase. Expected read data comes
// from a shadow memory holding the latest accepted write-back per word, which
// is what a coherent responder must return in either build.
// -----------------------------------------------------------------------------
module tb_cache_mem_responder;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MW  = 1024;
    localparam int WD  = 4;
    localparam int LAT = 3;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_address;
    logic [DW-1:0] wb_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_address;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_resp_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] shadow  [MW];
    bit            written [MW];

    always #5 clk = ~clk;

    cache_mem_responder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_WORDS   (MW),
        .WB_DEPTH    (WD),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_address    (wb_address),
        .wb_data       (wb_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_address    (rd_address),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one write-back for the next posedge.
    task automatic push(input logic [31:0] a, input logic [31:0] d, output bit acc);
        acc        = wb_ready;
        wb_valid   = 1'b1;
        wb_address = a;
        wb_data    = d;
        @(negedge clk);
        wb_valid   = 1'b0;
        if (acc) begin
            shadow[a[11:2]]  = d;
            written[a[11:2]] = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 500), 32'd1);
    endtask

    // lat = number of cycles from the accept edge to the response cycle.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat, output logic busy_acc);
        int g = 0;
        rd_valid   = 1'b1;
        rd_address = a;
        while (!rd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("rd_accept_timeout", 32'(g < 200), 32'd1);
        busy_acc = busy;
        @(negedge clk);
        rd_valid = 1'b0;
        lat = 1;
        while (!rd_resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = rd_resp_data;
        @(negedge clk);
        check("rd_resp_pulse", 32'(rd_resp_valid), 32'd0);
    endtask

    initial begin
        bit            acc;
        logic [31:0]   d;
        logic [31:0]   v;
        int            lat;
        logic          bacc;
        int            seen;
        logic [31:0]   a;

        for (int i = 0; i < MW; i++) begin
            written[i] = 1'b0;
            shadow[i]  = '0;
        end
        rst = 1'b1; wb_valid = 1'b0; rd_valid = 1'b0;
        wb_address = '0; wb_data = '0; rd_address = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
        check("rst_resp_data",  rd_resp_data,       32'd0);
        check("rst_busy",       32'(busy),          32'd0);
        check("rst_wb_ready",   32'(wb_ready),      32'd1);
        check("rst_rd_ready",   32'(rd_ready),      32'd1);

        // Write-back then miss read of 0x40
        push(32'h40, 32'hDEADBEEF, acc);
        check("wb40_acc", 32'(acc), 32'd1);
        wait_idle();
        do_read(32'h40, d, lat, bacc);
        check("rd40_data", d, shadow[16]);
        check("rd40_lat",  32'(lat), 32'(LAT));

        // Four back-to-back pushes fill the buffer; fifth is ignored
        for (int k = 0; k < 4; k++) begin
            push(32'h100 + 32'(4*k), $urandom, acc);
            check("fill_acc", 32'(acc), 32'd1);
        end
        check("full_wb_ready", 32'(wb_ready), 32'd0);
        v = shadow[64];
        push(32'h100, 32'h55555555, acc);
        check("fifth_acc", 32'(acc), 32'd0);
        check("wb_ready_after_pop", 32'(wb_ready), 32'd1);
        wait_idle();
        check("fifth_not_stored", shadow[64], v);
        for (int k = 0; k < 4; k++) begin
            a = 32'h100 + 32'(4*k);
            do_read(a, d, lat, bacc);
            check("fill_rd_data", d, shadow[a[11:2]]);
        end

        // Two write-backs to the same word, read immediately
        push(32'h80, 32'h11111111, acc);
        push(32'h80, 32'h22222222, acc);
        do_read(32'h80, d, lat, bacc);
        check("same_word_data", d, 32'h22222222);
        check("same_word_lat",  32'(lat), FWD ? 32'd1 : 32'(LAT));
        check("same_word_busy_at_accept", 32'(bacc), FWD ? 32'd1 : 32'd0);
        wait_idle();

        // Reset during READ_WAIT drops the read
        rd_valid   = 1'b1;
        rd_address = 32'h40;
        seen = 0;
        while (!rd_ready && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        @(negedge clk);
        rd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_rd_ready", 32'(rd_ready), 32'd1);
        check("rstmid_busy",     32'(busy),     32'd0);
        seen = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            if (rd_resp_valid) seen++;
            @(negedge clk);
        end
        check("rstmid_no_resp", 32'(seen), 32'd0);
        do_read(32'h40, d, lat, bacc);
        check("mem_survives_rst", d, 32'hDEADBEEF);

        // Push coinciding with a drain pop while two entries are buffered
        push(32'h300, $urandom, acc);
        push(32'h304, $urandom, acc);
        repeat (LAT - 1) @(negedge clk);
        check("pp_wb_ready_before", 32'(wb_ready), 32'd1);
        push(32'h308, $urandom, acc);
        check("pp_acc", 32'(acc), 32'd1);
        check("pp_count", 32'(dut.u_fifo.count_r), 32'd2);
        check("pp_wb_ready_after", 32'(wb_ready), 32'd1);
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            a = 32'h300 + 32'(4*k);
            do_read(a, d, lat, bacc);
            check("pp_rd_data", d, shadow[a[11:2]]);
        end

        // Randomized mix of write-backs and reads over 16 words
        for (int it = 0; it < 80; it++) begin
            a = 32'h200 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0 || !written[a[11:2]]) begin
                push(a, $urandom, acc);
            end else begin
                v = shadow[a[11:2]];
                do_read(a, d, lat, bacc);
                check("rnd_rd_data", d, v);
                check("rnd_rd_lat", 32'((lat == LAT) || (FWD && lat == 1)), 32'd1);
            end
        end
        wait_idle();
        for (int k = 0; k < 16; k++) begin
            a = 32'h200 + 32'(4*k);
            if (written[a[11:2]]) begin
                do_read(a, d, lat, bacc);
                check("rnd_final_data", d, shadow[a[11:2]]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the two-way write-back data cache. It accepts dirty-line write-backs into a small posted write buffer and serves refill reads from a word-addressed backing store with fixed latency. When enabled, it forwards read data from buffered write-backs so a refill never returns stale data. It sits between the cache's miss/eviction path and the main-memory array.

## Interface

- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- MEM_WORDS, 1024, backing-store depth in words (power of two)
- WB_DEPTH, 4, write-buffer entries (power of two, ≥2)
- MEM_LATENCY, 3, cycles per backing-store access (≥2)

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  write-back request
- wb_ready  out  1  write buffer not full
- wb_address  in  ADDR_WIDTH  write-back byte address (bits [1:0] ignored)
- wb_data  in  DATA_WIDTH  write-back data
- rd_valid  in  1  refill read request
- rd_ready  out  1  read can be accepted this cycle
- rd_address  in  ADDR_WIDTH  refill byte address (bits [1:0] ignored)
- rd_resp_valid  out  1  one-cycle response pulse
- rd_resp_data  out  DATA_WIDTH  response data, valid only with rd_resp_valid
- busy  out  1  high when state ≠ IDLE or write buffer non-empty

## Operation

- Word index is addr[2 +: log2(MEM_WORDS)]. Forwarding compares the full addr[ADDR_WIDTH-1:2].
- Push happens when wb_valid && wb_ready. wb_ready = !full, combinational from the count. Push and pop in the same cycle leave the count unchanged. A push while full is ignored.
- FSM has three states: IDLE, READ_WAIT, DRAIN.
- In IDLE, a read accept (rd_valid && rd_ready) has priority over draining.
  - On a forward hit, go to IDLE and register the data from the youngest matching buffer entry.
  - On a miss, go to READ_WAIT and load the latency counter.
- In IDLE with no read accepted and the buffer non-empty, go to DRAIN.
- READ_WAIT: after MEM_LATENCY cycles, register mem[index] into rd_resp_data, pulse rd_resp_valid, then go to IDLE.
- DRAIN: the head entry stays in the FIFO for the whole access. On the final cycle, write mem[index] and pop the entry, then go to IDLE. Every drain returns to IDLE for at least one cycle, so a waiting read is never starved.
- rd_ready = (state == IDLE). When WB_FORWARD_EN is absent, it additionally requires an empty buffer.
- Reset clears: state = IDLE, FIFO empty, rd_resp_valid = 0, rd_resp_data = 0, busy = 0, wb_ready = 1, rd_ready = 1.
- Reset mid-read drops the read with no response. Reset discards all buffered write-backs. Memory contents are not reset.

## Timing

- Read accepted at edge T:
  - forward hit: rd_resp_valid high in cycle T+1;
  - miss: rd_resp_valid high in cycle T+MEM_LATENCY.
- rd_ready is low from T+1 until the response cycle. It is high in the response cycle, so back-to-back reads are possible.
- A drain entered at edge D commits at edge D+MEM_LATENCY. wb_ready rises in the cycle after the pop.
- A write-back pushed in the same cycle a read is accepted is not visible to that read.

## Configuration

- WB_FORWARD_EN defined:
  - reads are accepted while the buffer is non-empty;
  - the youngest matching entry is forwarded with 1-cycle latency;
  - when nothing matches, the read is served from memory (buffered non-matching entries cannot alias).
- WB_FORWARD_EN undefined:
  - no compare logic is built;
  - rd_ready stays low until the buffer has fully drained, which guarantees coherence by ordering.

## Structure

- Shared package cache_mem_pkg holds:
  - state enum resp_state_t (IDLE, READ_WAIT, DRAIN);
  - word-index width function;
  - latency-counter width constant.
- One sub-module, wb_fifo: WB_DEPTH entries of {address, data}, with push, pop, full, empty, and a flat entry/valid view for the forwarding compare.

## Test plan

- Reset, then write mem[0x40] via write-back 0x40 / 0xDEADBEEF and wait for busy = 0. Read 0x40 → rd_resp_valid exactly 3 cycles after accept with 0xDEADBEEF.
- Push four write-backs back to back (0x100..0x10C) with a held rd_valid low → wb_ready low after the fourth push. A fifth push is ignored. All four reach memory in FIFO order.
- WB_FORWARD_EN: push 0x80/0x11111111 then 0x80/0x22222222, read 0x80 immediately → response 1 cycle after accept with 0x22222222.
- Without WB_FORWARD_EN: same stimulus → rd_ready low until both drains complete; the response equals 0x22222222 after the memory latency.
- Assert rst during READ_WAIT → no rd_resp_valid follows; rd_ready = 1 and busy = 0 the cycle after reset.
- Simultaneous push and drain pop with two entries buffered → count stays 2 and wb_ready stays 1.
